// File: rtl/input_frame_scheduler_if.sv
// Valid/ready word channel from the input frame scheduler to the game-logic input port.
// The scheduler drives the master side; the consumer drives out_ready from the slave side.
interface input_frame_scheduler_if #(
  parameter int WIDTH = 10
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_player;

  modport master (
    output out_valid,
    output out_data,
    output out_player,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_player,
    output out_ready
  );
endinterface

// File: rtl/input_frame_scheduler.sv
// Snapshots NUM_PLAYERS control words per frame and issues them round-robin, rotating the first player.
// Optional macro SKIP_IDLE_EN: players whose snapshotted word is zero are skipped.
module input_frame_scheduler #(
  parameter int WIDTH       = 10,
  parameter int NUM_PLAYERS = 2,
  parameter int FCNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [NUM_PLAYERS*WIDTH-1:0] ctrl_in,
  input  logic                         clear_overrun,
  input_frame_scheduler_if.master      out_bus,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         overrun,
  output logic [FCNT_W-1:0]            frame_count
);

  // Storage is sized for the 4-player maximum so 2-bit pointers index it without width games.
  localparam int MAXP = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [WIDTH-1:0]      snap [MAXP];
  logic [MAXP-1:0]       pending;
  logic [MAXP-1:0]       tick_mask;
  logic [MAXP-1:0]       pending_after;
  logic [1:0]            first_ptr;
  logic [1:0]            cur_ptr;
  logic [1:0]            sel_ptr;
  logic [MAXP*WIDTH-1:0] ctrl_pad;
  logic                  xfer;
  logic                  tick_busy;

  function automatic logic [1:0] wrap_inc(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PLAYERS) s = s - NUM_PLAYERS;
    return s[1:0];
  endfunction

  assign ctrl_pad = (MAXP*WIDTH)'(ctrl_in);

  always_comb begin
    tick_mask = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
`ifdef SKIP_IDLE_EN
      tick_mask[p] = |ctrl_pad[p*WIDTH +: WIDTH];
`else
      tick_mask[p] = 1'b1;
`endif
    end
  end

  // Scan from the largest offset down so the nearest pending player at or after cur_ptr wins.
  always_comb begin
    sel_ptr = cur_ptr;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (pending[wrap_inc(cur_ptr, k)]) sel_ptr = wrap_inc(cur_ptr, k);
    end
  end

  assign xfer      = (state == S_ISSUE) && out_bus.out_ready;
  assign tick_busy = frame_tick && (state != S_IDLE);

  always_comb begin
    pending_after = pending;
    if (xfer) pending_after[sel_ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pending     <= '0;
      first_ptr   <= '0;
      cur_ptr     <= '0;
      frame_count <= '0;
      for (int p = 0; p < MAXP; p++) snap[p] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            for (int p = 0; p < MAXP; p++) snap[p] <= ctrl_pad[p*WIDTH +: WIDTH];
            pending     <= tick_mask;
            cur_ptr     <= first_ptr;
            first_ptr   <= wrap_inc(first_ptr, 1);
            frame_count <= frame_count + FCNT_W'(1);
            state       <= (tick_mask == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            pending <= pending_after;
            cur_ptr <= wrap_inc(sel_ptr, 1);
            if (pending_after == '0) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A tick that cannot be accepted outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset)             overrun <= 1'b0;
    else if (tick_busy)     overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

  assign out_bus.out_valid  = (state == S_ISSUE);
  assign out_bus.out_data   = (state == S_ISSUE) ? snap[sel_ptr] : '0;
  assign out_bus.out_player = (state == S_ISSUE) ? sel_ptr : 2'd0;
  assign busy               = (state == S_ISSUE);
  assign frame_done         = (state == S_DONE);

endmodule
